// File: rtl/cash_dispenser.sv
// cash_dispenser: greedy three-cassette note planner and motor pulse sequencer.
// Defining CASH_DISPENSER_JAM_DETECT_EN adds exit-slot jam detection on note_sensed.
module cash_dispenser #(
    parameter int balance_width = 20,
    parameter int DENOM_HI      = 200,
    parameter int DENOM_MID     = 50,
    parameter int DENOM_LO      = 10,
    parameter int CNT_W         = 8,
    parameter int INIT_COUNT    = 100,
    parameter int MAX_NOTES     = 40,
    parameter int PULSE_GAP     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [balance_width-1:0] amount,
    input  logic                     refill,
    input  logic                     note_sensed,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [2:0]               note_pulse,
    output logic [CNT_W-1:0]         inv_hi,
    output logic [CNT_W-1:0]         inv_mid,
    output logic [CNT_W-1:0]         inv_lo
);

    // state    | meaning
    // IDLE     | waiting for start or refill
    // PLAN     | one greedy planning step per cycle
    // DISPENSE | one-cycle motor strobe for the highest planned note
    // GAP      | motor settle window between notes
    // DONE     | one-cycle done pulse
    // FAIL     | one-cycle fail pulse, plan discarded
    typedef enum logic [2:0] {
        S_IDLE, S_PLAN, S_DISPENSE, S_GAP, S_DONE, S_FAIL
    } state_t;

    localparam int PLAN_W = $clog2(MAX_NOTES + 1);
    localparam int GAP_W  = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

    localparam logic [balance_width-1:0] D_HI     = balance_width'(DENOM_HI);
    localparam logic [balance_width-1:0] D_MID    = balance_width'(DENOM_MID);
    localparam logic [balance_width-1:0] D_LO     = balance_width'(DENOM_LO);
    localparam logic [PLAN_W-1:0]        MAX_N    = PLAN_W'(MAX_NOTES);
    localparam logic [CNT_W-1:0]         INIT_INV = CNT_W'(INIT_COUNT);
    localparam logic [GAP_W-1:0]         GAP_LOAD = GAP_W'(PULSE_GAP - 1);

    state_t                   state, state_nxt;
    logic [balance_width-1:0] residual;
    logic [PLAN_W-1:0]        plan_hi, plan_mid, plan_lo;
    logic [PLAN_W-1:0]        total;
    logic [GAP_W-1:0]         gap_cnt;

    logic can_hi, can_mid, can_lo, over_max;
    logic step_hi, step_mid, step_lo;
    logic pick_hi, pick_mid, plan_any;
    logic jammed;

    assign total    = plan_hi + plan_mid + plan_lo;
    assign can_hi   = (residual >= D_HI)  && (32'(plan_hi)  < 32'(inv_hi));
    assign can_mid  = (residual >= D_MID) && (32'(plan_mid) < 32'(inv_mid));
    assign can_lo   = (residual >= D_LO)  && (32'(plan_lo)  < 32'(inv_lo));
    assign over_max = (total == MAX_N) && (residual != '0);

    assign step_hi  = !over_max && can_hi;
    assign step_mid = !over_max && !can_hi && can_mid;
    assign step_lo  = !over_max && !can_hi && !can_mid && can_lo;

    assign pick_hi  = (plan_hi != '0);
    assign pick_mid = !pick_hi && (plan_mid != '0);
    assign plan_any = (plan_hi != '0) || (plan_mid != '0) || (plan_lo != '0);

`ifdef CASH_DISPENSER_JAM_DETECT_EN
    // Sticky record of the exit sensor over the current GAP window.
    logic sensed_seen;

    assign jammed = !(sensed_seen || note_sensed);

    always_ff @(posedge clk) begin
        if (rst)
            sensed_seen <= 1'b0;
        else if (state == S_DISPENSE)
            sensed_seen <= 1'b0;
        else if ((state == S_GAP) && note_sensed)
            sensed_seen <= 1'b1;
    end
`else
    logic unused_note_sensed;

    assign jammed             = 1'b0;
    assign unused_note_sensed = note_sensed;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (start && !refill)
                    state_nxt = S_PLAN;
            S_PLAN:
                if (over_max)
                    state_nxt = S_FAIL;
                else if (can_hi || can_mid || can_lo)
                    state_nxt = S_PLAN;
                else if ((residual == '0) && (total != '0))
                    state_nxt = S_DISPENSE;
                else
                    state_nxt = S_FAIL;
            S_DISPENSE:
                state_nxt = S_GAP;
            S_GAP:
                if (gap_cnt == '0) begin
                    if (jammed)
                        state_nxt = S_FAIL;
                    else if (plan_any)
                        state_nxt = S_DISPENSE;
                    else
                        state_nxt = S_DONE;
                end
            S_DONE:
                state_nxt = S_IDLE;
            S_FAIL:
                state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        fail       = (state == S_FAIL);
        note_pulse = 3'b000;
        if (state == S_DISPENSE) begin
            if (pick_hi)
                note_pulse = 3'b100;
            else if (pick_mid)
                note_pulse = 3'b010;
            else
                note_pulse = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            residual <= '0;
            plan_hi  <= '0;
            plan_mid <= '0;
            plan_lo  <= '0;
            gap_cnt  <= '0;
            inv_hi   <= INIT_INV;
            inv_mid  <= INIT_INV;
            inv_lo   <= INIT_INV;
        end else begin
            case (state)
                S_IDLE: begin
                    if (refill) begin
                        inv_hi  <= INIT_INV;
                        inv_mid <= INIT_INV;
                        inv_lo  <= INIT_INV;
                    end else if (start) begin
                        residual <= amount;
                        plan_hi  <= '0;
                        plan_mid <= '0;
                        plan_lo  <= '0;
                    end
                end
                S_PLAN: begin
                    if (step_hi) begin
                        plan_hi  <= plan_hi + PLAN_W'(1);
                        residual <= residual - D_HI;
                    end else if (step_mid) begin
                        plan_mid <= plan_mid + PLAN_W'(1);
                        residual <= residual - D_MID;
                    end else if (step_lo) begin
                        plan_lo  <= plan_lo + PLAN_W'(1);
                        residual <= residual - D_LO;
                    end
                end
                S_DISPENSE: begin
                    gap_cnt <= GAP_LOAD;
                    if (pick_hi) begin
                        plan_hi <= plan_hi - PLAN_W'(1);
                        inv_hi  <= inv_hi - CNT_W'(1);
                    end else if (pick_mid) begin
                        plan_mid <= plan_mid - PLAN_W'(1);
                        inv_mid  <= inv_mid - CNT_W'(1);
                    end else begin
                        plan_lo <= plan_lo - PLAN_W'(1);
                        inv_lo  <= inv_lo - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt != '0)
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                S_DONE: begin
                    residual <= '0;
                end
                S_FAIL: begin
                    // A jam abort arrives here with notes still planned; drop them.
                    residual <= '0;
                    plan_hi  <= '0;
                    plan_mid <= '0;
                    plan_lo  <= '0;
                end
                default: begin
                    residual <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cash_dispenser.sv
// tb_cash_dispenser: randomized and directed checks of cash_dispenser against a
// transaction-level model that expands each accepted request into a per-cycle output trace.
module tb_cash_dispenser;

    localparam int BW   = 20;
    localparam int INIT = 100;
    localparam int GAP  = 3;
    localparam int MAXN = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          refill = 1'b0;
    logic          note_sensed = 1'b0;
    logic [BW-1:0] amount = '0;
    logic          busy, done, fail;
    logic [2:0]    note_pulse;
    logic [7:0]    inv_hi, inv_mid, inv_lo;

    cash_dispenser dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .amount      (amount),
        .refill      (refill),
        .note_sensed (note_sensed),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .note_pulse  (note_pulse),
        .inv_hi      (inv_hi),
        .inv_mid     (inv_mid),
        .inv_lo      (inv_lo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected per-cycle outputs: {busy, done, fail, note_pulse[2:0]}
    logic [5:0] exp_q[$];
    int m_hi = INIT, m_mid = INIT, m_lo = INIT;
    bit m_busy = 1'b0;
    bit armed  = 1'b0;
    int cyc    = 0;

    int         pulse_n = 0;
    logic [2:0] pulse_val[$];
    int         pulse_at[$];
    int         done_n = 0, done_at = 0, fail_n = 0, fail_at = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Greedy breakdown by plain arithmetic, then the cycle-by-cycle output sequence.
    task automatic build_trace(input int amt, input bit jam);
        int n_hi, n_mid, n_lo, r, total, plan_cycles;
        logic [2:0] order[$];
        n_hi = amt / 200;
        if (n_hi > m_hi) n_hi = m_hi;
        r = amt - 200 * n_hi;
        n_mid = r / 50;
        if (n_mid > m_mid) n_mid = m_mid;
        r = r - 50 * n_mid;
        n_lo = r / 10;
        if (n_lo > m_lo) n_lo = m_lo;
        r = r - 10 * n_lo;
        total = n_hi + n_mid + n_lo;
        plan_cycles = ((total > MAXN) ? MAXN : total) + 1;
        for (int i = 0; i < plan_cycles; i++) exp_q.push_back(6'b100_000);
        if (total == 0 || r != 0 || total > MAXN) begin
            exp_q.push_back(6'b101_000);
            return;
        end
        repeat (n_hi)  order.push_back(3'b100);
        repeat (n_mid) order.push_back(3'b010);
        repeat (n_lo)  order.push_back(3'b001);
        foreach (order[i]) begin
            exp_q.push_back({3'b100, order[i]});
            repeat (GAP) exp_q.push_back(6'b100_000);
            if (jam) begin
                exp_q.push_back(6'b101_000);
                return;
            end
        end
        exp_q.push_back(6'b110_000);
    endtask

    // Predict the effect of the coming edge from the current inputs, advance one
    // cycle, then compare every output against the model.
    task automatic tick();
        logic [5:0] e;
        bit jam;
        if (rst) begin
            exp_q.delete();
            m_hi  = INIT;
            m_mid = INIT;
            m_lo  = INIT;
            armed = 1'b1;
        end else if (armed && !m_busy) begin
            if (refill) begin
                m_hi  = INIT;
                m_mid = INIT;
                m_lo  = INIT;
            end else if (start) begin
`ifdef CASH_DISPENSER_JAM_DETECT_EN
                jam = !note_sensed;
`else
                jam = 1'b0;
`endif
                build_trace(int'(amount), jam);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (armed) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 6'b000_000;
            m_busy = e[5];
            check("busy", busy, e[5]);
            check("done", done, e[4]);
            check("fail", fail, e[3]);
            check("note_pulse", note_pulse, e[2:0]);
            check("inv_hi", inv_hi, m_hi);
            check("inv_mid", inv_mid, m_mid);
            check("inv_lo", inv_lo, m_lo);
            case (e[2:0])
                3'b100: m_hi--;
                3'b010: m_mid--;
                3'b001: m_lo--;
                default: ;
            endcase
        end
        if (note_pulse != 3'b000) begin
            pulse_n++;
            pulse_val.push_back(note_pulse);
            pulse_at.push_back(cyc);
        end
        if (done === 1'b1) begin done_n++; done_at = cyc; end
        if (fail === 1'b1) begin fail_n++; fail_at = cyc; end
`ifndef CASH_DISPENSER_JAM_DETECT_EN
        note_sensed = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        start  = 1'b0;
        refill = 1'b0;
        while ((exp_q.size() > 0 || m_busy) && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0 || m_busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic run(input int amt);
        amount = BW'(amt);
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(400);
    endtask

    task automatic do_refill();
        refill = 1'b1;
        tick();
        refill = 1'b0;
        tick();
    endtask

    task automatic clear_log();
        pulse_n = 0;
        pulse_val.delete();
        pulse_at.delete();
        done_n = 0;
        fail_n = 0;
    endtask

    initial begin
        int t0;
        int mids;
`ifdef CASH_DISPENSER_JAM_DETECT_EN
        note_sensed = 1'b1;
`endif
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_pulse", note_pulse, 0);
        check("rst_inv_hi", inv_hi, 100);
        check("rst_inv_lo", inv_lo, 100);

        // 260 -> hi, mid, lo, 4 cycles apart, done 4 cycles after last pulse
        clear_log();
        run(260);
        check("t260_pulses", pulse_n, 3);
        check("t260_done_n", done_n, 1);
        if (pulse_val.size() == 3) begin
            check("t260_p0", pulse_val[0], 3'b100);
            check("t260_p1", pulse_val[1], 3'b010);
            check("t260_p2", pulse_val[2], 3'b001);
            check("t260_gap01", pulse_at[1] - pulse_at[0], 4);
            check("t260_gap12", pulse_at[2] - pulse_at[1], 4);
            check("t260_done_lat", done_at - pulse_at[2], 4);
        end
        check("t260_inv_hi", inv_hi, 99);
        check("t260_inv_mid", inv_mid, 99);
        check("t260_inv_lo", inv_lo, 99);

        // 35 is not a multiple of 10
        do_refill();
        clear_log();
        run(35);
        check("t35_fail_n", fail_n, 1);
        check("t35_pulses", pulse_n, 0);
        check("t35_done_n", done_n, 0);
        check("t35_inv_hi", inv_hi, 100);
        check("t35_inv_lo", inv_lo, 100);

        // Drain the high cassette, then 400 must come out as 8 mid notes
        do_refill();
        for (int i = 0; i < 100 && m_hi > 0; i++) run(210);
        check("drain_inv_hi", inv_hi, 0);
        clear_log();
        run(400);
        mids = 0;
        foreach (pulse_val[i]) if (pulse_val[i] == 3'b010) mids++;
        check("t400_pulses", pulse_n, 8);
        check("t400_mids", mids, 8);
        check("t400_done_n", done_n, 1);
        check("t400_inv_hi", inv_hi, 0);
        check("t400_inv_mid", inv_mid, 92);

        // 5000 with no high notes: 40 mids planned with residual left
        clear_log();
        amount = BW'(5000);
        start  = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        wait_idle(400);
        check("t5000_fail_n", fail_n, 1);
        check("t5000_pulses", pulse_n, 0);
        check("t5000_fail_lat", fail_at - t0, 41);
        check("t5000_inv_mid", inv_mid, 92);

        // start pulsed while busy is ignored
        do_refill();
        clear_log();
        amount = BW'(260);
        start  = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            start  = (i % 5 == 2);
            amount = BW'(50);
            tick();
        end
        wait_idle(400);
        check("busy_start_pulses", pulse_n, 3);
        check("busy_start_done_n", done_n, 1);
        check("busy_start_inv_mid", inv_mid, 99);

        // start together with refill: refill wins
        amount = BW'(260);
        start  = 1'b1;
        refill = 1'b1;
        tick();
        start  = 1'b0;
        refill = 1'b0;
        tick();
        check("start_refill_busy", busy, 0);
        check("start_refill_inv_mid", inv_mid, 100);

        // reset in the middle of a transaction
        clear_log();
        amount = BW'(260);
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_busy", busy, 0);
        check("midrst_done_n", done_n, 0);
        check("midrst_fail_n", fail_n, 0);
        check("midrst_inv_hi", inv_hi, 100);

        clear_log();
`ifdef CASH_DISPENSER_JAM_DETECT_EN
        note_sensed = 1'b0;
        run(60);
        note_sensed = 1'b1;
        check("jam_pulses", pulse_n, 1);
        if (pulse_val.size() > 0) check("jam_p0", pulse_val[0], 3'b010);
        check("jam_fail_n", fail_n, 1);
        check("jam_done_n", done_n, 0);
        check("jam_inv_mid", inv_mid, 99);
        check("jam_inv_lo", inv_lo, 100);
`else
        run(60);
        check("t60_pulses", pulse_n, 2);
        check("t60_done_n", done_n, 1);
        check("t60_inv_mid", inv_mid, 99);
        check("t60_inv_lo", inv_lo, 99);
`endif

        // Random traffic: starts, refills, resets and amounts of all kinds
        for (int i = 0; i < 5000; i++) begin
            rst    = ($urandom_range(0, 399) == 0);
            refill = ($urandom_range(0, 29) == 0);
            start  = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0:       amount = BW'($urandom_range(0, 1000) * 10);
                1:       amount = BW'($urandom_range(0, 2000));
                default: amount = BW'($urandom_range(0, 150) * 10);
            endcase
            tick();
        end
        rst = 1'b0;
        wait_idle(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
